ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

AHB-lite responder serving the 64-bit transfers issued by the core's bus interface unit and cache bus unit: decodes the address/control phase, drives HREADYOUT/HRESP/HRDATA, and maps accepted beats onto a single-port synchronous SRAM with byte enables. It sits on the system AHB as the on-chip RAM slave behind the bus master arbiter. Zero-wait reads and writes, one wait state only on a read that immediately follows a write, two-cycle ERROR response for illegal accesses.

## Interface
- ADDR_WIDTH, 12: SRAM word-address width (64-bit words; 12 → 32 KiB).
- BASE_ADDR, 64'h0000_0000_8000_0000: byte base address of the RAM window.

- clk  in  1  single clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- hsel  in  1  slave select.
- haddr  in  64  byte address (address phase).
- hwrite  in  1  1 = write.
- hsize  in  3  0=byte,1=half,2=word,3=dword; 4–7 illegal.
- hburst  in  3  ignored (each beat decoded independently).
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hmastlock  in  1  ignored.
- hwdata  in  64  write data (data phase).
- hready  in  1  bus-level ready; address phase accepted only when 1.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 OKAY, 1 ERROR.
- hrdata  out  64  read data.
- sram_ce  out  1  SRAM access enable.
- sram_we  out  1  SRAM write enable.
- sram_be  out  8  byte enables, bit i = byte lane i.
- sram_addr  out  ADDR_WIDTH  word address.
- sram_wdata  out  64  SRAM write data.
- sram_rdata  in  64  SRAM read data, valid one cycle after read issue.

## Operation
- Accept = hsel & hready & htrans[1]. IDLE/BUSY or unselected: OKAY, no SRAM access.
- Decode: off = haddr − BASE_ADDR. Error if haddr < BASE_ADDR, off ≥ 8<<ADDR_WIDTH, hsize > 3, or haddr not aligned to 1<<hsize. Word address = off[ADDR_WIDTH+2:3].
- Byte enables (little-endian lanes): size0 → 1<<a[2:0]; size1 → 8'h03<<{a[2:1],1'b0}; size2 → 8'h0F<<{a[2],2'b00}; size3 → 8'hFF. Writes to non-enabled lanes never alter SRAM.
- hrdata returns the full 64-bit word; master selects lanes. hrdata = 0 outside read data phases.
- States: IDLE, RD, WR, RD_ISSUE, ERR1, ERR2.
  - IDLE/RD/WR/ERR2 (hreadyout=1): accepted read → sram_ce=1, we=0, combinational addr, next RD; accepted write → latch addr/be, next WR; accepted illegal → ERR1; else IDLE.
  - WR: sram_ce=we=1, latched addr/be, sram_wdata=hwdata. Concurrent accepted read collides on SRAM port → latch read addr, next RD_ISSUE. Concurrent write or error handled as above.
  - RD_ISSUE: hreadyout=0, sram read with latched addr → RD.
  - RD: hrdata=sram_rdata, hreadyout=1.
  - ERR1: hreadyout=0, hresp=1, no access → ERR2. ERR2: hreadyout=1, hresp=1.
- Read after write to same address returns new data (write committed first).

## Timing
- Reset: state IDLE, hreadyout=1, hresp=0, hrdata=0, sram_ce=0, sram_we=0, sram_be=0. Reset mid-write drops the write (we=0 from that edge).
- Read: address at T0 → data/OKAY at T1 (zero wait). Write: address T0 → SRAM write and OKAY at T1.
- Read in address phase during write data phase: read data phase gets exactly one wait state.
- Error: exactly two data-phase cycles (0/1 then 1/1); no SRAM access; next address phase sampled only in ERR2.
- Back-to-back writes/reads in bursts: one beat per cycle, no bubbles.

## Test plan
- Reset then idle: hreadyout=1, hresp=0, hrdata=0, sram_ce=0 for 10 cycles with htrans=IDLE.
- Write dword 64'h1122334455667788 to BASE+0x10, then read → sram_be=8'hFF at T1, read returns the value at T3 with one wait state at T2.
- Byte write 8'hAA to BASE+0x13 over that word → sram_be=8'h08; readback 64'h11223344AA667788.
- INCR4 word read burst from BASE+0x0 → four OKAY beats, hreadyout never low, data matches preloaded words.
- Access BASE−8, BASE+(8<<ADDR_WIDTH), and half at BASE+0x1 → each gives hreadyout=0,hresp=1 then hreadyout=1,hresp=1, sram_ce=0 throughout.
- Assert rst during WR state → sram_we=0 next cycle, state IDLE, target word unchanged.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-lite bus signals seen by the on-chip RAM slave.
// The slave modport is used by ahb_sram_slave; the master modport by whoever drives the bus.
interface ahb_sram_slave_if;
    logic        hsel;
    logic [63:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [1:0]  htrans;
    logic        hmastlock;
    logic [63:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [63:0] hrdata;

    modport slave (
        input  hsel, haddr, hwrite, hsize, hburst, htrans, hmastlock, hwdata, hready,
        output hreadyout, hresp, hrdata
    );

    modport master (
        output hsel, haddr, hwrite, hsize, hburst, htrans, hmastlock, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-lite responder for a 64-bit single-port synchronous SRAM with byte enables.
// Reads and writes are zero-wait; a read whose address phase overlaps a write data
// phase gets one wait state (RD_ISSUE) because the SRAM port is busy with the write.
// Illegal accesses get the two-cycle ERROR response and never touch the SRAM.
module ahb_sram_slave #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    ahb_sram_slave_if.slave       ahb,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [7:0]            sram_be,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [63:0]           sram_wdata,
    input  logic [63:0]           sram_rdata
);
    localparam logic [63:0] WIN_BYTES = 64'd8 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RD_ISSUE,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_be_q, wr_be_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic                  accept;
    logic [63:0]           off;
    logic                  misalign;
    logic                  dec_err;
    logic [ADDR_WIDTH-1:0] dec_addr;
    logic [7:0]            dec_be;
    logic                  sample_state;
    logic                  rd_now;

    // Burst type and lock have no effect: every beat is decoded on its own.
    logic unused_ok;
    assign unused_ok = ^{ahb.hburst, ahb.hmastlock};

    // Address-phase decode: window check, size/alignment check, word address and lanes.
    always_comb begin
        accept   = ahb.hsel & ahb.hready & ahb.htrans[1];
        off      = ahb.haddr - BASE_ADDR;
        misalign = 1'b0;
        case (ahb.hsize)
            3'd1:    misalign = ahb.haddr[0];
            3'd2:    misalign = |ahb.haddr[1:0];
            3'd3:    misalign = |ahb.haddr[2:0];
            default: misalign = 1'b0;
        endcase
        dec_err  = (ahb.haddr < BASE_ADDR) | (off >= WIN_BYTES) | ahb.hsize[2] | misalign;
        dec_addr = off[ADDR_WIDTH+2:3];
        case (ahb.hsize)
            3'd0:    dec_be = 8'h01 << ahb.haddr[2:0];
            3'd1:    dec_be = 8'h03 << {ahb.haddr[2:1], 1'b0};
            3'd2:    dec_be = 8'h0F << {ahb.haddr[2], 2'b00};
            default: dec_be = 8'hFF;
        endcase
        // States with hreadyout=1 are the only ones that sample a new address phase.
        sample_state = (state_q == S_IDLE) || (state_q == S_RD) ||
                       (state_q == S_WR)   || (state_q == S_ERR2);
        // A legal read can go straight to the SRAM unless a write owns the port this cycle.
        rd_now = sample_state & accept & ~dec_err & ~ahb.hwrite & (state_q != S_WR);
    end

    // State and latched-address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
            wr_be_q   <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_be_q   <= wr_be_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Next-state logic: accept a new beat in ready states, walk the wait/error states otherwise.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_be_d   = wr_be_q;
        rd_addr_d = rd_addr_q;
        case (state_q)
            S_IDLE, S_RD, S_WR, S_ERR2: begin
                if (accept) begin
                    if (dec_err) begin
                        state_d = S_ERR1;
                    end else if (ahb.hwrite) begin
                        state_d   = S_WR;
                        wr_addr_d = dec_addr;
                        wr_be_d   = dec_be;
                    end else if (state_q == S_WR) begin
                        state_d   = S_RD_ISSUE;
                        rd_addr_d = dec_addr;
                    end else begin
                        state_d = S_RD;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD_ISSUE: state_d = S_RD;
            S_ERR1:     state_d = S_ERR2;
            default:    state_d = S_IDLE;
        endcase
    end

    // Output logic: bus response per state plus the SRAM command for this cycle.
    always_comb begin
        ahb.hreadyout = 1'b1;
        ahb.hresp     = 1'b0;
        ahb.hrdata    = '0;
        sram_ce       = 1'b0;
        sram_we       = 1'b0;
        sram_be       = '0;
        sram_addr     = '0;
        sram_wdata    = '0;
        case (state_q)
            S_WR: begin
                sram_ce    = 1'b1;
                sram_we    = 1'b1;
                sram_be    = wr_be_q;
                sram_addr  = wr_addr_q;
                sram_wdata = ahb.hwdata;
            end
            S_RD: begin
                ahb.hrdata = sram_rdata;
            end
            S_RD_ISSUE: begin
                ahb.hreadyout = 1'b0;
                sram_ce       = 1'b1;
                sram_be       = 8'hFF;
                sram_addr     = rd_addr_q;
            end
            S_ERR1: begin
                ahb.hreadyout = 1'b0;
                ahb.hresp     = 1'b1;
            end
            S_ERR2: begin
                ahb.hresp = 1'b1;
            end
            default: ;
        endcase
        if (rd_now) begin
            sram_ce   = 1'b1;
            sram_we   = 1'b0;
            sram_be   = 8'hFF;
            sram_addr = dec_addr;
        end
        // Reset kills any access in flight, so a write caught by reset never commits.
        if (rst) begin
            sram_ce = 1'b0;
            sram_we = 1'b0;
        end
    end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: directed AHB beats, a behavioural SRAM, and a
// scoreboard queue drained by an independent data-phase monitor.
module tb_ahb_sram_slave;
    localparam int          AW   = 12;
    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic preload = 1'b1;
    always #5 clk = ~clk;

    ahb_sram_slave_if bus();
    assign bus.hready = bus.hreadyout;

    logic          sram_ce, sram_we;
    logic [7:0]    sram_be;
    logic [AW-1:0] sram_addr;
    logic [63:0]   sram_wdata, sram_rdata;

    ahb_sram_slave #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst        (rst),
        .ahb        (bus),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // Behavioural SRAM: byte-masked writes, read data one cycle after issue.
    // Word i is preloaded with {C0DE, i, 5A5A, i}.
    logic [63:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1 << AW); i++)
                mem[i] <= {16'hC0DE, 16'(i), 16'h5A5A, 16'(i)};
        end else if (sram_ce) begin
            if (sram_we) begin
                for (int b = 0; b < 8; b++)
                    if (sram_be[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= mem[sram_addr];
            end
        end
    end

    typedef struct {
        logic        is_err;
        logic [63:0] data;
        int          waits;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Monitor: tracks data phases and compares each completed one against the queue head.
    initial begin : monitor
        bit   dp;
        int   waits;
        exp_t e;
        dp    = 1'b0;
        waits = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dp    = 1'b0;
                waits = 0;
            end else begin
                if (dp) begin
                    if (!bus.hreadyout) begin
                        waits++;
                        if (exp_q.size() > 0 && exp_q[0].is_err)
                            check64({exp_q[0].name, " err1 hresp"}, 64'(bus.hresp), 64'd1);
                    end else begin
                        if (exp_q.size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL unexpected data phase: got hresp=%b hrdata=%h required none", bus.hresp, bus.hrdata);
                        end else begin
                            e = exp_q.pop_front();
                            $display("txn %-12s resp=%0d rdata=%h waits=%0d", e.name, bus.hresp, bus.hrdata, waits);
                            check64({e.name, " hresp"}, 64'(bus.hresp), 64'(e.is_err));
                            check64({e.name, " hrdata"}, bus.hrdata, e.data);
                            check64({e.name, " waits"}, 64'(waits), 64'(e.waits));
                        end
                        waits = 0;
                    end
                end
                if (bus.hreadyout) dp = bus.hsel & bus.htrans[1];
            end
        end
    end

    // Drive one address phase, wait for it to be accepted, queue its expected response,
    // then present write data for its data phase.
    task automatic beat(input string name, input logic [63:0] addr, input logic wr,
                        input logic [2:0] size, input logic [1:0] trans, input logic [63:0] wdata,
                        input logic is_err, input logic [63:0] exp_data, input int exp_waits);
        int   guard;
        exp_t e;
        bus.hsel   = 1'b1;
        bus.haddr  = addr;
        bus.hwrite = wr;
        bus.hsize  = size;
        bus.htrans = trans;
        guard = 0;
        @(negedge clk);
        while (!bus.hreadyout && guard < 20) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s accept timeout: got hreadyout=%b required 1", name, bus.hreadyout);
        end
        e.is_err = is_err;
        e.data   = exp_data;
        e.waits  = exp_waits;
        e.name   = name;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (wr) bus.hwdata = wdata;
    endtask

    task automatic idle();
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        @(posedge clk);
        #1;
    endtask

    task automatic err_beat(input string name, input logic [63:0] addr, input logic wr, input logic [2:0] size);
        beat(name, addr, wr, size, 2'b10, 64'h0, 1'b1, 64'h0, 1);
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        check64({name, " ce err1"}, 64'(sram_ce), 64'd0);
        @(posedge clk);
        #1;
        check64({name, " ce err2"}, 64'(sram_ce), 64'd0);
    endtask

    initial begin : stim
        int guard;
        bus.hsel      = 1'b0;
        bus.haddr     = '0;
        bus.hwrite    = 1'b0;
        bus.hsize     = 3'd3;
        bus.hburst    = 3'b000;
        bus.htrans    = 2'b00;
        bus.hmastlock = 1'b0;
        bus.hwdata    = '0;

        repeat (3) @(posedge clk);
        #1;
        rst     = 1'b0;
        preload = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check64("idle hreadyout", 64'(bus.hreadyout), 64'd1);
            check64("idle hresp",     64'(bus.hresp),     64'd0);
            check64("idle hrdata",    bus.hrdata,         64'd0);
            check64("idle sram_ce",   64'(sram_ce),       64'd0);
            check64("idle sram_be",   64'(sram_be),       64'd0);
        end
        @(posedge clk);
        #1;

        // Dword write then immediate read of the same word: one wait state.
        beat("wr_d_10", BASE + 64'h10, 1'b1, 3'd3, 2'b10, 64'h1122334455667788, 1'b0, 64'h0, 0);
        check64("wr_d_10 we", 64'(sram_we), 64'd1);
        check64("wr_d_10 be", 64'(sram_be), 64'hFF);
        beat("rd_d_10", BASE + 64'h10, 1'b0, 3'd3, 2'b10, 64'h0, 1'b0, 64'h1122334455667788, 1);
        idle();
        idle();

        // Byte write lane 3, then readback.
        beat("wr_b_13", BASE + 64'h13, 1'b1, 3'd0, 2'b10, 64'hFFFF_FFFF_AAFF_FFFF, 1'b0, 64'h0, 0);
        check64("wr_b_13 be", 64'(sram_be), 64'h08);
        beat("rd_b_13", BASE + 64'h10, 1'b0, 3'd3, 2'b10, 64'h0, 1'b0, 64'h1122_3344_AA66_7788, 1);
        idle();

        // Half write lanes 6-7, then readback after an idle cycle (no wait).
        beat("wr_h_16", BASE + 64'h16, 1'b1, 3'd1, 2'b10, 64'hBEEF_0000_0000_0000, 1'b0, 64'h0, 0);
        check64("wr_h_16 be", 64'(sram_be), 64'hC0);
        idle();
        beat("rd_h_16", BASE + 64'h10, 1'b0, 3'd3, 2'b10, 64'h0, 1'b0, 64'hBEEF_3344_AA66_7788, 0);
        idle();

        // INCR4 word read burst from the base: preloaded words 0,0,1,1, no waits.
        bus.hburst = 3'b011;
        beat("incr4_0", BASE + 64'h0, 1'b0, 3'd2, 2'b10, 64'h0, 1'b0, 64'hC0DE_0000_5A5A_0000, 0);
        beat("incr4_1", BASE + 64'h4, 1'b0, 3'd2, 2'b11, 64'h0, 1'b0, 64'hC0DE_0000_5A5A_0000, 0);
        beat("incr4_2", BASE + 64'h8, 1'b0, 3'd2, 2'b11, 64'h0, 1'b0, 64'hC0DE_0001_5A5A_0001, 0);
        beat("incr4_3", BASE + 64'hC, 1'b0, 3'd2, 2'b11, 64'h0, 1'b0, 64'hC0DE_0001_5A5A_0001, 0);
        bus.hburst = 3'b000;
        idle();

        // Back-to-back writes then back-to-back reads.
        beat("wr_20", BASE + 64'h20, 1'b1, 3'd3, 2'b10, 64'h0123_4567_89AB_CDEF, 1'b0, 64'h0, 0);
        beat("wr_28", BASE + 64'h28, 1'b1, 3'd3, 2'b11, 64'hFEDC_BA98_7654_3210, 1'b0, 64'h0, 0);
        check64("wr_28 addr", 64'(sram_addr), 64'd5);
        beat("rd_20", BASE + 64'h20, 1'b0, 3'd3, 2'b10, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF, 1);
        beat("rd_28", BASE + 64'h28, 1'b0, 3'd3, 2'b11, 64'h0, 1'b0, 64'hFEDC_BA98_7654_3210, 0);
        idle();

        // Illegal accesses: below window, past window end, misaligned half.
        err_beat("err_below", BASE - 64'h8, 1'b0, 3'd3);
        err_beat("err_above", BASE + 64'h8000, 1'b1, 3'd3);
        err_beat("err_half1", BASE + 64'h1, 1'b0, 3'd1);
        idle();

        // Reset while in the write data phase drops the write.
        beat("wr_rst", BASE + 64'h30, 1'b1, 3'd3, 2'b10, 64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 64'h0, 0);
        rst        = 1'b1;
        bus.hsel   = 1'b0;
        bus.htrans = 2'b00;
        @(posedge clk);
        #1;
        check64("rst sram_we",   64'(sram_we),       64'd0);
        check64("rst hreadyout", 64'(bus.hreadyout), 64'd1);
        check64("rst hresp",     64'(bus.hresp),     64'd0);
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        beat("rd_after_rst", BASE + 64'h30, 1'b0, 3'd3, 2'b10, 64'h0, 1'b0, 64'hC0DE_0006_5A5A_0006, 0);
        idle();
        idle();

        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            guard++;
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending responses required 0", exp_q.size());
        end
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
